// File: rtl/xm_mem_responder.sv
// xm_mem_responder: memory-side responder for the X-Makina multi-cycle core.
// Holds a byte-addressable little-endian word memory, inserts WAIT wait states
// per access and reports completion (and rejected accesses) with a one-cycle
// ready pulse.
module xm_mem_responder #(
    parameter int WORD  = 16,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            wr_i,
    input  logic            byteOp_i,
    input  logic [15:0]     addr_i,
    input  logic [WORD-1:0] data_i,
    output logic            ready_o,
    output logic            fault_o,
    output logic [WORD-1:0] data_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [16:0] BYTE_LIMIT = 17'(2 * DEPTH);
    localparam logic [3:0]  WAIT_CNT   = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            byte_op_q, byte_op_d;
    logic [15:0]     addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [WORD-1:0] rdata_q, rdata_d;

    logic [WORD-1:0] mem_q [DEPTH];

    logic [AW-1:0]   word_idx;
    logic [WORD-1:0] mem_word;
    logic [WORD-1:0] rd_value;
    logic [WORD-1:0] mem_wdata;
    logic            access_fault;
    logic            mem_we;

    // Decode the latched access: word index, fault condition, read value and merged write word
    always_comb begin
        word_idx     = addr_q[AW:1];
        mem_word     = mem_q[word_idx];
        access_fault = (!byte_op_q && addr_q[0]) || ({1'b0, addr_q} >= BYTE_LIMIT);
        if (!byte_op_q) begin
            rd_value  = mem_word;
            mem_wdata = wdata_q;
        end else if (addr_q[0]) begin
            rd_value  = {8'h00, mem_word[15:8]};
            mem_wdata = {wdata_q[7:0], mem_word[7:0]};
        end else begin
            rd_value  = {8'h00, mem_word[7:0]};
            mem_wdata = {mem_word[15:8], wdata_q[7:0]};
        end
    end

    // Next-state and output logic; BUSY's last decrement and the move to DONE share an edge
    // so BUSY lasts exactly WAIT cycles and a request occupies WAIT+2 cycles in total
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        byte_op_d = byte_op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        ready_o   = 1'b0;
        fault_o   = 1'b0;
        data_o    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    wr_d      = wr_i;
                    byte_op_d = byteOp_i;
                    addr_d    = addr_i;
                    wdata_d   = data_i;
                    cnt_d     = WAIT_CNT;
                    state_d   = (WAIT_CNT == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!rst_i) begin
                    ready_o = 1'b1;
                    fault_o = access_fault;
                    if (!access_fault) begin
                        if (wr_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_d = rd_value;
                            data_o  = rd_value;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and latched-request registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            byte_op_q <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            byte_op_q <= byte_op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory array write port; contents survive reset, the write enable is already blocked by reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_xm_mem_responder.sv
// Testbench for xm_mem_responder: directed table, multi-cycle corner sequences,
// and randomized accesses checked against a byte-array reference model.
module tb_xm_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, byte_op;
    logic [15:0] addr, wdata;
    logic        use_w0;

    logic        req_a, req_b;
    logic        rdy_a, flt_a, rdy_b, flt_b;
    logic [15:0] dat_a, dat_b;
    logic        ready, fault;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mbytes [2*DEPTH];
    logic [15:0] last_rd;

    typedef struct {
        logic        w;
        logic        b;
        logic [15:0] a;
        logic [15:0] d;
        logic        f;
        logic [15:0] q;
    } vec_t;

    vec_t vecs [15];

    assign req_a = req & ~use_w0;
    assign req_b = req & use_w0;
    assign ready = use_w0 ? rdy_b : rdy_a;
    assign fault = use_w0 ? flt_b : flt_a;
    assign rdata = use_w0 ? dat_b : dat_a;

    xm_mem_responder #(.WORD(16), .DEPTH(DEPTH), .WAIT(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .wr_i(wr), .byteOp_i(byte_op),
        .addr_i(addr), .data_i(wdata), .ready_o(rdy_a), .fault_o(flt_a), .data_o(dat_a)
    );

    xm_mem_responder #(.WORD(16), .DEPTH(DEPTH), .WAIT(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .wr_i(wr), .byteOp_i(byte_op),
        .addr_i(addr), .data_i(wdata), .ready_o(rdy_b), .fault_o(flt_b), .data_o(dat_b)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: byte array, little-endian, fault rules applied to the request fields
    task automatic modelStep(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                             output logic ef, output logic [15:0] eq);
        int ai;
        ai = int'(a);
        ef = (!b && a[0]) || (ai >= 2 * DEPTH);
        if (!ef) begin
            if (w) begin
                mbytes[ai] = d[7:0];
                if (!b) mbytes[ai+1] = d[15:8];
            end else begin
                last_rd = b ? {8'h00, mbytes[ai]} : {mbytes[ai+1], mbytes[ai]};
            end
        end
        eq = last_rd;
    endtask

    task automatic applyStimulus(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                                 output logic f, output logic [15:0] q, output int lat);
        @(negedge clk);
        checkOutput("ready_idle", 32'(ready), 32'd0);
        req = 1'b1; wr = w; byte_op = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'($urandom); byte_op = 1'($urandom);
        addr = 16'($urandom); wdata = 16'($urandom);
        lat = 0; f = 1'b0; q = 16'h0000;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i; f = fault; q = rdata;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string name, input logic w, input logic b, input logic [15:0] a,
                               input logic [15:0] d, input logic ef, input logic [15:0] eq);
        logic        f;
        logic [15:0] q;
        int          lat;
        applyStimulus(w, b, a, d, f, q, lat);
        checkOutput({name, "_latency"}, 32'(lat), use_w0 ? 32'd1 : 32'd3);
        checkOutput({name, "_fault"}, 32'(f), 32'(ef));
        checkOutput({name, "_data"}, 32'(q), 32'(eq));
    endtask

    logic        mf, rw, rb;
    logic [15:0] mq, ra, rd, old_word;
    logic [15:0] b2b_exp [3];
    int          sel;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; byte_op = 1'b0;
        addr = 16'h0000; wdata = 16'h0000; use_w0 = 1'b0; last_rd = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_ready_a", 32'(rdy_a), 32'd0);
        checkOutput("reset_fault_a", 32'(flt_a), 32'd0);
        checkOutput("reset_data_a", 32'(dat_a), 32'd0);
        checkOutput("reset_ready_b", 32'(rdy_b), 32'd0);
        checkOutput("reset_data_b", 32'(dat_b), 32'd0);

        // Directed table: {wr, byteOp, addr, data, fault, data_o during ready}
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b1, 1'b1, 16'h0021, 16'h77AB, 1'b0, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAB34};
        vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h0034};
        vecs[6]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0, 16'h00AB};
        vecs[7]  = '{1'b1, 1'b0, 16'h0011, 16'h5555, 1'b1, 16'h00AB};
        vecs[8]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[9]  = '{1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'hBEEF};
        vecs[11] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hBEEF};
        vecs[12] = '{1'b1, 1'b0, 16'h07FE, 16'h0F0F, 1'b0, 16'hBEEF};
        vecs[13] = '{1'b0, 1'b1, 16'h07FF, 16'h0000, 1'b0, 16'h000F};
        vecs[14] = '{1'b0, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h0F0F};
        for (int i = 0; i < 15; i++) begin
            modelStep(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, mf, mq);
            runAndCheck($sformatf("vec%0d", i), vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d,
                        vecs[i].f, vecs[i].q);
        end

        // Preload the low window so random reads compare against known contents
        for (int k = 0; k < 64; k++) begin
            rd = 16'($urandom);
            modelStep(1'b1, 1'b0, 16'(2 * k), rd, mf, mq);
            runAndCheck("preload", 1'b1, 1'b0, 16'(2 * k), rd, mf, mq);
        end

        // Back-to-back reads with req_i held high and inputs churning outside IDLE
        for (int k = 0; k < 3; k++) begin
            modelStep(1'b0, 1'b0, 16'(16'h0030 + 2 * k), 16'h0000, mf, mq);
            b2b_exp[k] = mq;
        end
        @(negedge clk);
        req = 1'b1; wr = 1'b0; byte_op = 1'b0; addr = 16'h0030;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_ready_c%0d", i), 32'(ready), 32'((i % 4) == 3));
            if ((i % 4) == 3) begin
                checkOutput($sformatf("b2b_data_c%0d", i), 32'(rdata), 32'(b2b_exp[i/4]));
                checkOutput($sformatf("b2b_fault_c%0d", i), 32'(fault), 32'd0);
            end
            if (i == 4 || i == 8) begin
                req = 1'b1; wr = 1'b0; byte_op = 1'b0; addr = 16'(16'h0030 + 2 * (i / 4));
            end else begin
                req = (i < 8); wr = 1'($urandom); byte_op = 1'($urandom);
                addr = 16'($urandom); wdata = 16'($urandom);
            end
        end

        // Reset in the BUSY cycle aborts a write; simultaneous req and reset drops the request
        modelStep(1'b0, 1'b0, 16'h0040, 16'h0000, mf, old_word);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; byte_op = 1'b0; addr = 16'h0040; wdata = 16'hCAFE;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 16'h0000;
        checkOutput("abort_data_reset", 32'(rdata), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("abort_no_ready", 32'(ready), 32'd0);
        end
        modelStep(1'b0, 1'b0, 16'h0040, 16'h0000, mf, mq);
        runAndCheck("abort_readback", 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, old_word);
        @(negedge clk);
        rst = 1'b1; req = 1'b1; wr = 1'b1; byte_op = 1'b0; addr = 16'h0042; wdata = 16'hDEAD;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        last_rd = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rstreq_no_ready", 32'(ready), 32'd0);
        end
        modelStep(1'b0, 1'b0, 16'h0042, 16'h0000, mf, mq);
        runAndCheck("rstreq_readback", 1'b0, 1'b0, 16'h0042, 16'h0000, mf, mq);

        // Randomized accesses against the reference model
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)       ra = 16'($urandom_range(0, 127));
            else if (sel == 7)  ra = 16'($urandom_range(2046, 2047));
            else if (sel == 8)  ra = 16'($urandom_range(2048, 65535));
            else                ra = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0800;
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
            modelStep(rw, rb, ra, rd, mf, mq);
            runAndCheck($sformatf("rand%0d", n), rw, rb, ra, rd, mf, mq);
        end

        // Zero-wait-state build: one-cycle latency and two cycles per access
        use_w0 = 1'b1;
        runAndCheck("w0_write", 1'b1, 1'b0, 16'h0010, 16'h1357, 1'b0, 16'h0000);
        runAndCheck("w0_read", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1357);
        runAndCheck("w0_bwrite", 1'b1, 1'b1, 16'h0011, 16'h009A, 1'b0, 16'h1357);
        runAndCheck("w0_bread", 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h009A);
        runAndCheck("w0_misalign", 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h009A);
        @(negedge clk);
        req = 1'b1; wr = 1'b0; byte_op = 1'b0; addr = 16'h0010;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w0_b2b_ready_c%0d", i), 32'(ready), 32'((i % 2) == 1));
            if ((i % 2) == 1) begin
                checkOutput($sformatf("w0_b2b_data_c%0d", i), 32'(rdata), 32'h9A57);
            end
            if (i == 2 || i == 4) begin
                req = 1'b1; wr = 1'b0; byte_op = 1'b0; addr = 16'h0010;
            end else begin
                req = (i < 4); wr = 1'($urandom); byte_op = 1'($urandom);
                addr = 16'($urandom); wdata = 16'($urandom);
            end
        end
        req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
